// File: rtl/interrupt_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_pkg
//   Definitions shared by the interrupt path: the InterruptController and
//   the interrupt_dispatcher that sits between the controller and the CPU.
//
//   Contents:
//     WORD_W     - machine word width (12 bits)
//     IRQ_NONE   - next_interrupt value meaning "nothing pending"
//     disp_state_t - dispatcher FSM encoding (IDLE=0, REQ=1, DISMISS=2,
//                    SERVICE=3)
//     ctl_cmd_t  - one command on the controller's command bus
//     is_pending - helper: true when a next_interrupt value names a line
// -----------------------------------------------------------------------------
package interrupt_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t IRQ_NONE = 12'o7777;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISMISS = 2'd2,
    ST_SERVICE = 2'd3
  } disp_state_t;

  // One cycle's worth of traffic on the controller command bus.
  typedef struct packed {
    logic  dismiss;
    logic  create;
    word_t data;
  } ctl_cmd_t;

  localparam ctl_cmd_t CTL_CMD_IDLE = '{dismiss: 1'b0, create: 1'b0, data: '0};

  function automatic logic is_pending(input word_t num);
    return (num != IRQ_NONE);
  endfunction

endpackage

// File: rtl/irq_vector_gen.sv
// -----------------------------------------------------------------------------
// irq_vector_gen
//   Purely combinational vector address generator:
//     vector = (BASE + (num << SHIFT)) mod 2^WORD_W
//   Kept separate so trap entry logic can reuse the same table layout.
//
//   Parameters:
//     BASE   - base address of the vector table
//     SHIFT  - log2 of words per vector entry
//   Ports:
//     num    in  WORD_W  interrupt / trap number
//     vector out WORD_W  handler address
// -----------------------------------------------------------------------------
module irq_vector_gen
  import interrupt_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE  = 12'o0100,
  parameter int                SHIFT = 1
) (
  input  logic [WORD_W-1:0] num,
  output logic [WORD_W-1:0] vector
);

  logic [WORD_W-1:0] offset;

  // Bits shifted out the top are dropped: the table wraps modulo 2^WORD_W,
  // so large software numbers still land on a well-defined address.
  assign offset = num << SHIFT;
  assign vector = BASE + offset;

endmodule

// File: rtl/interrupt_dispatcher.sv
// -----------------------------------------------------------------------------
// interrupt_dispatcher
//   Sits between the InterruptController and the CPU core. It watches the
//   controller's next_interrupt, raises a request/acknowledge handshake to
//   the CPU when interrupts are enabled and no handler is active, supplies
//   the handler vector, dismisses the taken interrupt at the controller, and
//   tracks single-level in-service state until the CPU returns.
//   It also owns the controller command bus, passing CPU software
//   create/dismiss commands through except in the one cycle it needs the bus.
//
//   CPU handshake: irq_req rises with irq_num/irq_vector valid and all three
//   stay stable until the CPU pulses irq_ack; the request drops on the edge
//   that samples irq_ack. cpu_busy=1 in a cycle means the CPU command
//   presented that cycle was not forwarded and must be reissued.
//
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     next_interrupt  highest-priority pending number (IRQ_NONE = none)
//     ie_set, ie_clr  enable / disable strobes (clear wins)
//     irq_ack         CPU takes the request
//     irq_return      CPU returns from the handler
//     cpu_dismiss, cpu_create, cpu_data   CPU software command
//     irq_req, irq_vector, irq_num        request, handler address, number
//     ie, in_service  enable flag, handler active
//     cpu_busy        CPU command rejected this cycle
//     ctl_dismiss, ctl_create, ctl_data   controller command bus
//     dbg_state       current FSM state (interrupt_pkg::disp_state_t)
// -----------------------------------------------------------------------------
module interrupt_dispatcher
  import interrupt_pkg::*;
#(
  parameter logic [WORD_W-1:0] VECTOR_BASE  = 12'o0100,
  parameter int                VECTOR_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] next_interrupt,
  input  logic              ie_set,
  input  logic              ie_clr,
  input  logic              irq_ack,
  input  logic              irq_return,
  input  logic              cpu_dismiss,
  input  logic              cpu_create,
  input  logic [WORD_W-1:0] cpu_data,
  output logic              irq_req,
  output logic [WORD_W-1:0] irq_vector,
  output logic [WORD_W-1:0] irq_num,
  output logic              ie,
  output logic              in_service,
  output logic              cpu_busy,
  output logic              ctl_dismiss,
  output logic              ctl_create,
  output logic [WORD_W-1:0] ctl_data,
  output logic [1:0]        dbg_state
);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  disp_state_t       state_q, state_d;
  logic              ie_q, ie_d;
  logic              irq_req_q, irq_req_d;
  logic [WORD_W-1:0] irq_num_q, irq_num_d;
  logic              in_service_q, in_service_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ie_q         <= 1'b0;
      irq_req_q    <= 1'b0;
      irq_num_q    <= IRQ_NONE;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ie_q         <= ie_d;
      irq_req_q    <= irq_req_d;
      irq_num_q    <= irq_num_d;
      in_service_q <= in_service_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Enable flag: independent of the FSM, clear beats set.
  // ---------------------------------------------------------------------------
  always_comb begin
    ie_d = ie_q;
    if (ie_clr) begin
      ie_d = 1'b0;
    end else if (ie_set) begin
      ie_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    irq_req_d    = irq_req_q;
    irq_num_d    = irq_num_q;
    in_service_d = in_service_q;

    unique case (state_q)
      ST_IDLE: begin
        // Uses the registered enable, so an ie_set takes one edge to count.
        if (ie_q && is_pending(next_interrupt)) begin
          state_d   = ST_REQ;
          irq_num_d = next_interrupt;
          irq_req_d = 1'b1;
        end
      end

      ST_REQ: begin
        // The number is frozen here; a later higher-priority arrival waits
        // for the next pass through IDLE. ie changes do not cancel.
        if (irq_ack) begin
          state_d   = ST_DISMISS;
          irq_req_d = 1'b0;
        end
      end

      ST_DISMISS: begin
        state_d      = ST_SERVICE;
        in_service_d = 1'b1;
      end

      ST_SERVICE: begin
        // Single-level: nothing is requested until the handler returns.
        // irq_num stays readable until the next capture.
        if (irq_return) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Combinational outputs: controller command bus mux and CPU back-pressure
  // ---------------------------------------------------------------------------
  ctl_cmd_t ctl_cmd;
  logic     cpu_busy_c;

  always_comb begin
    ctl_cmd    = CTL_CMD_IDLE;
    cpu_busy_c = 1'b0;
    if (!rst) begin
      // Drop any command while reset is held so the controller sees nothing.
      ctl_cmd    = CTL_CMD_IDLE;
      cpu_busy_c = 1'b0;
    end else if (state_q == ST_DISMISS) begin
      ctl_cmd.dismiss = 1'b1;
      ctl_cmd.create  = 1'b0;
      ctl_cmd.data    = irq_num_q;
      cpu_busy_c      = cpu_dismiss | cpu_create;
    end else begin
      ctl_cmd.dismiss = cpu_dismiss;
      ctl_cmd.create  = cpu_create;
      ctl_cmd.data    = cpu_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector generation from the registered number: valid alongside irq_req.
  // ---------------------------------------------------------------------------
  irq_vector_gen #(
    .BASE  (VECTOR_BASE),
    .SHIFT (VECTOR_SHIFT)
  ) u_vector_gen (
    .num    (irq_num_q),
    .vector (irq_vector)
  );

  assign irq_req     = irq_req_q;
  assign irq_num     = irq_num_q;
  assign ie          = ie_q;
  assign in_service  = in_service_q;
  assign cpu_busy    = cpu_busy_c;
  assign ctl_dismiss = ctl_cmd.dismiss;
  assign ctl_create  = ctl_cmd.create;
  assign ctl_data    = ctl_cmd.data;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_interrupt_dispatcher
//   Directed bench for interrupt_dispatcher. Inputs change 1 time unit after
//   a rising edge and outputs are checked in the same window, well away from
//   the next edge.
// -----------------------------------------------------------------------------
module tb_interrupt_dispatcher;

  localparam logic [11:0] NONE = 12'o7777;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [11:0] next_interrupt = NONE;
  logic        ie_set = 1'b0, ie_clr = 1'b0, irq_ack = 1'b0, irq_return = 1'b0;
  logic        cpu_dismiss = 1'b0, cpu_create = 1'b0;
  logic [11:0] cpu_data = '0;
  logic        irq_req, ie, in_service, cpu_busy, ctl_dismiss, ctl_create;
  logic [11:0] irq_vector, irq_num, ctl_data;
  logic [1:0]  dbg_state;

  interrupt_dispatcher dut (
    .clk            (clk),
    .rst            (rst),
    .next_interrupt (next_interrupt),
    .ie_set         (ie_set),
    .ie_clr         (ie_clr),
    .irq_ack        (irq_ack),
    .irq_return     (irq_return),
    .cpu_dismiss    (cpu_dismiss),
    .cpu_create     (cpu_create),
    .cpu_data       (cpu_data),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_num        (irq_num),
    .ie             (ie),
    .in_service     (in_service),
    .cpu_busy       (cpu_busy),
    .ctl_dismiss    (ctl_dismiss),
    .ctl_create     (ctl_create),
    .ctl_data       (ctl_data),
    .dbg_state      (dbg_state)
  );

  // scoreboard counters
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %o expected %o", tag, obs, exp);
  endtask

  // driver: advance one rising edge, then move into the quiet window
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ---------------- reset, with CPU commands present ----------------
    cpu_dismiss = 1'b1; cpu_create = 1'b1; cpu_data = 12'o7000;
    step(2);
    check("rst_state",      dbg_state,   0);
    check("rst_ie",         ie,          0);
    check("rst_irq_req",    irq_req,     0);
    check("rst_irq_num",    irq_num,     NONE);
    check("rst_in_service", in_service,  0);
    check("rst_ctl_dis",    ctl_dismiss, 0);
    check("rst_ctl_cre",    ctl_create,  0);
    check("rst_ctl_data",   ctl_data,    0);
    check("rst_busy",       cpu_busy,    0);
    cpu_dismiss = 1'b0; cpu_create = 1'b0; cpu_data = '0;
    rst = 1'b1;

    // ---------------- enable, first interrupt ----------------
    ie_set = 1'b1;
    step();
    ie_set = 1'b0;
    check("ie_after_set", ie, 1);
    next_interrupt = 12'o0002;
    #1;
    check("req_not_yet", irq_req, 0);
    step();
    check("req_rise",  irq_req,    1);
    check("req_num",   irq_num,    12'o0002);
    check("req_vec",   irq_vector, 12'o0104);
    check("req_state", dbg_state,  1);

    // higher-priority arrival and a stray return while in REQ
    next_interrupt = 12'o0000;
    irq_return = 1'b1;
    step();
    irq_return = 1'b0;
    check("req_hold_num",   irq_num,   12'o0002);
    check("req_hold_req",   irq_req,   1);
    check("req_hold_state", dbg_state, 1);

    // acknowledge -> DISMISS, CPU create collides with the dispatcher
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("dis_state", dbg_state, 2);
    check("dis_req",   irq_req,   0);
    cpu_create = 1'b1; cpu_data = 12'o7000;
    #1;
    check("dis_ctl_dis",  ctl_dismiss, 1);
    check("dis_ctl_data", ctl_data,    12'o0002);
    check("dis_ctl_cre",  ctl_create,  0);
    check("dis_busy",     cpu_busy,    1);

    // SERVICE; the retried create passes straight through
    step();
    check("svc_state",     dbg_state,   3);
    check("svc_in_svc",    in_service,  1);
    check("retry_cre",     ctl_create,  1);
    check("retry_data",    ctl_data,    12'o7000);
    check("retry_dis",     ctl_dismiss, 0);
    check("retry_busy",    cpu_busy,    0);
    cpu_create = 1'b0; cpu_data = '0;

    // pending 0 with ie=1, plus a stray ack: nothing new while in service
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step(2);
    check("svc_no_req",   irq_req,   0);
    check("svc_hold",     dbg_state, 3);
    check("svc_num_kept", irq_num,   12'o0002);

    // return -> IDLE, then the pending 0 is captured on the next edge
    irq_return = 1'b1;
    step();
    irq_return = 1'b0;
    check("ret_state",  dbg_state,  0);
    check("ret_in_svc", in_service, 0);
    check("ret_req",    irq_req,    0);
    step();
    check("req2_rise", irq_req,    1);
    check("req2_num",  irq_num,    12'o0000);
    check("req2_vec",  irq_vector, 12'o0100);

    // ie_clr in REQ updates ie, request survives
    ie_clr = 1'b1;
    step();
    ie_clr = 1'b0;
    check("req2_ie",   ie,      0);
    check("req2_held", irq_req, 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    irq_return = 1'b1;
    step();
    irq_return = 1'b0;
    check("ret2_state", dbg_state, 0);

    // ie=0: pending interrupt never requested; set+clr together leaves 0
    step(2);
    check("ie0_no_req", irq_req, 0);
    ie_set = 1'b1; ie_clr = 1'b1;
    step();
    ie_set = 1'b0; ie_clr = 1'b0;
    check("setclr_ie", ie, 0);
    next_interrupt = 12'o0003;
    step(5);
    check("ie0_no_req3", irq_req,   0);
    check("ie0_idle",    dbg_state, 0);

    // vector wrap for a large number
    next_interrupt = 12'o3777;
    ie_set = 1'b1;
    step();
    ie_set = 1'b0;
    check("wrap_wait", irq_req, 0);
    step();
    check("wrap_req", irq_req,    1);
    check("wrap_num", irq_num,    12'o3777);
    check("wrap_vec", irq_vector, 12'o0076);

    // asynchronous reset in REQ
    rst = 1'b0;
    #2;
    check("arst_req",   irq_req,   0);
    check("arst_ie",    ie,        0);
    check("arst_state", dbg_state, 0);
    check("arst_num",   irq_num,   NONE);
    step();
    rst = 1'b1;
    step(3);
    check("post_rst_no_req", irq_req, 0);
    ie_set = 1'b1;
    step();
    ie_set = 1'b0;
    step();
    check("post_rst_req", irq_req, 1);
    check("post_rst_num", irq_num, 12'o3777);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
